// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl
// Run controller for the multi-cycle processor simulation. It holds the core in
// reset for RESET_CYCLES edges, then counts RUN cycles and watches the data
// memory write port. A store to RESULT_ADDR ends the run with pass/fail; running
// out of MAX_CYCLES ends it with timeout. The result is held until reset.
//
// Ports:
//   clk          in  1       single clock, rising edge
//   reset        in  1       synchronous, active-high
//   memwrite     in  1       store strobe from the core
//   dataadr      in  DATA_W  store address
//   writedata    in  DATA_W  store data
//   cpu_reset    out 1       reset to the core
//   running      out 1       high in RUN
//   done         out 1       high in DONE (sticky)
//   pass         out 1       result store matched PASS_VALUE (sticky)
//   fail         out 1       result store did not match (sticky)
//   timeout      out 1       MAX_CYCLES elapsed with no result store (sticky)
//   cycle_count  out CNT_W   RUN cycles elapsed
//   store_count  out CNT_W   stores seen in RUN, result store included
//   result_data  out DATA_W  data of the result store, or 0
//
// state | meaning
// ------+-----------------------------------------------------------
// HOLD  | core held in reset, hold_cnt counting release edges
// RUN   | core running, cycles and stores counted, result watched
// DONE  | verdict latched, everything frozen until reset
module sim_run_ctrl #(
   parameter int                 DATA_W       = 32,
   parameter int                 CNT_W        = 16,
   parameter int                 RESET_CYCLES = 2,
   parameter int                 MAX_CYCLES   = 50,
   parameter logic [DATA_W-1:0]  RESULT_ADDR  = 32'h54,
   parameter logic [DATA_W-1:0]  PASS_VALUE   = 32'd7,
   parameter bit                 HALT_ON_DONE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memwrite,
   input  logic [DATA_W-1:0] dataadr,
   input  logic [DATA_W-1:0] writedata,
   output logic              cpu_reset,
   output logic              running,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  store_count,
   output logic [DATA_W-1:0] result_data
);

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic               cpu_reset_q, cpu_reset_d;
   logic               running_q, running_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic               fail_q, fail_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
   logic [CNT_W-1:0]   store_count_q, store_count_d;
   logic [DATA_W-1:0]  result_data_q, result_data_d;

   logic               result_store;
   logic               pass_match;

   assign result_store = memwrite && (dataadr == RESULT_ADDR);
   assign pass_match   = (writedata == PASS_VALUE);

   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      cpu_reset_d   = cpu_reset_q;
      running_d     = running_q;
      done_d        = done_q;
      pass_d        = pass_q;
      fail_d        = fail_q;
      timeout_d     = timeout_q;
      cycle_count_d = cycle_count_q;
      store_count_d = store_count_q;
      result_data_d = result_data_q;

      case (state_q)
         HOLD: begin
            cpu_reset_d = 1'b1;
            running_d   = 1'b0;
            hold_cnt_d  = hold_cnt_q + 1'b1;
            // Release the core on the same edge we enter RUN, so its first
            // un-reset edge sees cycle_count = 0.
            if (hold_cnt_q == HOLD_LAST) begin
               state_d     = RUN;
               hold_cnt_d  = '0;
               cpu_reset_d = 1'b0;
               running_d   = 1'b1;
            end
         end

         RUN: begin
            cycle_count_d = cycle_count_q + 1'b1;
            if (memwrite) begin
               store_count_d = store_count_q + 1'b1;
            end
            // A result store wins over a timeout landing on the same edge.
            if (result_store) begin
               state_d       = DONE;
               running_d     = 1'b0;
               done_d        = 1'b1;
               cpu_reset_d   = HALT_ON_DONE;
               result_data_d = writedata;
               pass_d        = pass_match;
               fail_d        = !pass_match;
            end else if (cycle_count_q == CYC_LAST) begin
               state_d     = DONE;
               running_d   = 1'b0;
               done_d      = 1'b1;
               cpu_reset_d = HALT_ON_DONE;
               timeout_d   = 1'b1;
            end
         end

         DONE: begin
            cpu_reset_d = HALT_ON_DONE;
         end

         default: begin
            state_d = HOLD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= HOLD;
         hold_cnt_q    <= '0;
         cpu_reset_q   <= 1'b1;
         running_q     <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         fail_q        <= 1'b0;
         timeout_q     <= 1'b0;
         cycle_count_q <= '0;
         store_count_q <= '0;
         result_data_q <= '0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         cpu_reset_q   <= cpu_reset_d;
         running_q     <= running_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         fail_q        <= fail_d;
         timeout_q     <= timeout_d;
         cycle_count_q <= cycle_count_d;
         store_count_q <= store_count_d;
         result_data_q <= result_data_d;
      end
   end

   assign cpu_reset   = cpu_reset_q;
   assign running     = running_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = timeout_q;
   assign cycle_count = cycle_count_q;
   assign store_count = store_count_q;
   assign result_data = result_data_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl. Two instances share the stimulus: one with
// HALT_ON_DONE=1 (defaults) and one with HALT_ON_DONE=0. Expected output
// snapshots are queued before each edge and compared against both instances
// one time unit after it.
module tb_sim_run_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;

   logic        cr_a, run_a, dn_a, ps_a, fl_a, to_a;
   logic [15:0] cyc_a, stc_a;
   logic [31:0] res_a;
   logic        cr_b, run_b, dn_b, ps_b, fl_b, to_b;
   logic [15:0] cyc_b, stc_b;
   logic [31:0] res_b;

   always #5 clk = ~clk;

   sim_run_ctrl u_dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .cpu_reset(cr_a), .running(run_a), .done(dn_a),
      .pass(ps_a), .fail(fl_a), .timeout(to_a), .cycle_count(cyc_a),
      .store_count(stc_a), .result_data(res_a)
   );

   sim_run_ctrl #(.HALT_ON_DONE(1'b0)) u_nh (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .cpu_reset(cr_b), .running(run_b), .done(dn_b),
      .pass(ps_b), .fail(fl_b), .timeout(to_b), .cycle_count(cyc_b),
      .store_count(stc_b), .result_data(res_b)
   );

   logic [69:0] obs_a, obs_b;
   assign obs_a = {cr_a, run_a, dn_a, ps_a, fl_a, to_a, cyc_a, stc_a, res_a};
   assign obs_b = {cr_b, run_b, dn_b, ps_b, fl_b, to_b, cyc_b, stc_b, res_b};

   typedef struct {
      string       tag;
      logic [69:0] exp_a;
      logic [69:0] exp_b;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Snapshot layout: {cpu_reset, running, done, pass, fail, timeout,
   // cycle_count, store_count, result_data}. The HALT_ON_DONE=0 instance
   // matches except that cpu_reset stays low in DONE.
   task automatic push(input string tag, input bit cr, input bit run,
                       input bit dn, input bit ps, input bit fl, input bit to,
                       input int cyc, input int stc, input logic [31:0] res);
      exp_t e;
      e.tag   = tag;
      e.exp_a = {cr, run, dn, ps, fl, to, 16'(cyc), 16'(stc), res};
      e.exp_b = {(dn ? 1'b0 : cr), run, dn, ps, fl, to, 16'(cyc), 16'(stc), res};
      q.push_back(e);
   endtask

   task automatic tick(input logic rst, input logic mw, input logic [31:0] a,
                       input logic [31:0] d);
      exp_t e;
      reset     = rst;
      memwrite  = mw;
      dataadr   = a;
      writedata = d;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         assert (obs_a === e.exp_a) else begin
            errors++;
            $error("FAIL %s halt observed=%h expected=%h", e.tag, obs_a, e.exp_a);
         end
         checks++;
         assert (obs_b === e.exp_b) else begin
            errors++;
            $error("FAIL %s nohalt observed=%h expected=%h", e.tag, obs_b, e.exp_b);
         end
      end
   endtask

   task automatic reset_tick(input string tag);
      push(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(1'b1, 1'b0, 32'h0, 32'h0);
   endtask

   // Two HOLD edges after release; a store on the first must be ignored.
   task automatic release_seq(input logic mw_e0);
      push("hold_e0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(1'b0, mw_e0, 32'h54, 32'd7);
      push("hold_e1", 0, 1, 0, 0, 0, 0, 0, 0, 0);
      tick(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic run_idle(input int first_k, input int last_k, input int stc);
      for (int k = first_k; k <= last_k; k++) begin
         push("run", 0, 1, 0, 0, 0, 0, k + 1, stc, 0);
         tick(1'b0, 1'b0, 32'h0, 32'h0);
      end
   endtask

   initial begin
      reset     = 1'b1;
      memwrite  = 1'b0;
      dataadr   = '0;
      writedata = '0;

      // Reset sequence, then pass at RUN edge 10.
      for (int i = 0; i < 3; i++) reset_tick("reset_state");
      release_seq(1'b0);
      run_idle(0, 9, 0);
      push("pass", 1, 0, 1, 1, 0, 0, 11, 1, 32'd7);
      tick(1'b0, 1'b1, 32'h54, 32'd7);
      push("pass_frozen", 1, 0, 1, 1, 0, 0, 11, 1, 32'd7);
      tick(1'b0, 1'b1, 32'h54, 32'd5);
      push("pass_frozen", 1, 0, 1, 1, 0, 0, 11, 1, 32'd7);
      tick(1'b0, 1'b1, 32'h50, 32'd9);

      // Reset out of DONE, then fail with store counting.
      reset_tick("reset_from_done");
      release_seq(1'b0);
      for (int k = 0; k <= 7; k++) begin
         automatic bit mw  = (k == 3) || (k == 5);
         automatic int stc = (k >= 5) ? 2 : ((k >= 3) ? 1 : 0);
         push("count", 0, 1, 0, 0, 0, 0, k + 1, stc, 0);
         tick(1'b0, mw, 32'h50, 32'h1234);
      end
      push("fail", 1, 0, 1, 0, 1, 0, 9, 3, 32'd5);
      tick(1'b0, 1'b1, 32'h54, 32'd5);

      // Timeout with a non-result store on the last RUN edge.
      reset_tick("reset_state");
      release_seq(1'b0);
      run_idle(0, 48, 0);
      push("timeout", 1, 0, 1, 0, 0, 1, 50, 1, 0);
      tick(1'b0, 1'b1, 32'h50, 32'd7);
      push("timeout_frozen", 1, 0, 1, 0, 0, 1, 50, 1, 0);
      tick(1'b0, 1'b1, 32'h54, 32'd7);
      push("timeout_frozen", 1, 0, 1, 0, 0, 1, 50, 1, 0);
      tick(1'b0, 1'b1, 32'h54, 32'd5);

      // Result store exactly on the timeout edge.
      reset_tick("reset_state");
      release_seq(1'b0);
      run_idle(0, 48, 0);
      push("collide", 1, 0, 1, 1, 0, 0, 50, 1, 32'd7);
      tick(1'b0, 1'b1, 32'h54, 32'd7);

      // Mid-run reset at RUN edge 20, HOLD restart, then a short pass.
      reset_tick("reset_state");
      release_seq(1'b1);
      run_idle(0, 19, 0);
      reset_tick("midrun_reset");
      release_seq(1'b0);
      run_idle(0, 1, 0);
      push("pass2", 1, 0, 1, 1, 0, 0, 3, 1, 32'd7);
      tick(1'b0, 1'b1, 32'h54, 32'd7);
      push("pass2_frozen", 1, 0, 1, 1, 0, 0, 3, 1, 32'd7);
      tick(1'b0, 1'b0, 32'h0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Run controller for the multi-cycle processor simulation environment. It sequences the core's reset, counts execution cycles, and watches the data-memory write port for a store of the result word to a fixed address. It reports pass, fail or timeout and holds the result until reset. It sits beside `top` in the bench and drives `top`'s reset. It replaces the fixed release-after-one-cycle, stop-after-50-cycles sequence with a parametrised, self-checking one.

## Interface
Parameters:
- `DATA_W`, 32: width of `writedata`, `dataadr` and `result_data`.
- `CNT_W`, 16: width of `cycle_count` and `store_count`.
- `RESET_CYCLES`, 2: cycles `cpu_reset` is held after `reset` falls. Legal range is 1..2^CNT_W-1.
- `MAX_CYCLES`, 50: RUN cycles before timeout. Legal range is 1..2^CNT_W-1.
- `RESULT_ADDR`, 32'h54: address whose store ends the run.
- `PASS_VALUE`, 32'd7: data value that means pass.
- `HALT_ON_DONE`, 1: if 1, `cpu_reset` reasserts in DONE. If 0, the core keeps running after DONE.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `memwrite` in 1: store strobe from the core.
- `dataadr` in DATA_W: store address.
- `writedata` in DATA_W: store data.
- `cpu_reset` out 1: reset to the core.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE (sticky).
- `pass` out 1: result store matched `PASS_VALUE` (sticky).
- `fail` out 1: result store did not match (sticky).
- `timeout` out 1: `MAX_CYCLES` elapsed with no result store (sticky).
- `cycle_count` out CNT_W: RUN cycles elapsed.
- `store_count` out CNT_W: stores seen in RUN, result store included.
- `result_data` out DATA_W: data of the result store, or 0.

## Operation
- States are HOLD, RUN and DONE, all registered. Every output is a direct function of registers.
- Reset (`reset`=1) puts every output in its reset state, which holds for any cycle sampled with `reset` high, including mid-RUN and in DONE:
  - state = HOLD, `hold_cnt` = 0, `cpu_reset` = 1
  - `running` = `done` = `pass` = `fail` = `timeout` = 0
  - `cycle_count` = `store_count` = 0, `result_data` = 0
- HOLD:
  - `cpu_reset` = 1, and `memwrite` is ignored.
  - `hold_cnt` increments on each edge with `reset` low.
  - When `hold_cnt` == RESET_CYCLES-1 at an edge, the next state is RUN.
- RUN:
  - `cpu_reset` = 0, `running` = 1.
  - `cycle_count` increments each edge.
  - Each `memwrite`=1 increments `store_count`.
  - A result store is `memwrite` && `dataadr` == RESULT_ADDR. On one:
    - next state = DONE
    - `result_data` ← `writedata`
    - `pass` ← (`writedata` == PASS_VALUE)
    - `fail` ← the complement of that compare
  - Timeout: if `cycle_count` == MAX_CYCLES-1 with no result store that cycle, next state = DONE and `timeout` ← 1.
- DONE:
  - `running` = 0, `done` = 1. Flags, `cycle_count`, `store_count` and `result_data` are frozen.
  - `cpu_reset` = HALT_ON_DONE.
  - Further stores are ignored. Exit is only via `reset`.
- Simultaneous events:
  - A result store on the timeout cycle counts as the result: `pass` or `fail` is set and `timeout` stays 0.
  - A non-result store on the timeout cycle is counted in `store_count`, then DONE with `timeout` = 1.
- Exactly one of `pass`/`fail`/`timeout` is 1 whenever `done` = 1. All three are 0 otherwise.
- Address and data compares are full DATA_W, exact equality, unsigned.
- Counters cannot wrap because the legal ranges bound them below 2^CNT_W.

## Timing
- With `reset` released before edge E0, `cpu_reset` falls after edge E(RESET_CYCLES-1). The core's first un-reset edge sees `cycle_count` = 0.
- Event-to-flag latency is 1 cycle: a result store sampled at edge N gives `done`/`pass`/`fail` high and `running` low after N.
- Timeout is asserted after the MAX_CYCLES-th RUN edge. At that point `cycle_count` = MAX_CYCLES.
- On a result store at RUN edge k (0-based), the final `cycle_count` = k+1.
- `cpu_reset` reassertion in DONE (HALT_ON_DONE=1) is on the same edge as `done`.

## Test plan
- Reset sequence: RESET_CYCLES=2, `reset` high for 3 cycles then low. Required: `cpu_reset` = 1 for exactly 2 edges after release, then 0. `running` rises the same cycle.
- Pass: at RUN edge 10, store addr 0x54, data 7. Required: next cycle `done` = `pass` = 1, `fail` = `timeout` = 0, `result_data` = 7, `cycle_count` = 11, `cpu_reset` = 1.
- Fail and counting: non-result stores to 0x50 at edges 3 and 5, then a store of 0x54/data 5 at edge 8. Required: `fail` = 1, `store_count` = 3, `result_data` = 5.
- Timeout: MAX_CYCLES=50 and no result store. Required: `timeout` = 1 and `cycle_count` = 50 after the 50th RUN edge. Later stores to 0x54 leave all outputs unchanged.
- Collision: result store of 0x54/data 7 exactly on RUN edge 49 with MAX_CYCLES=50. Required: `pass` = 1 and `timeout` = 0.
- Mid-run reset, with HALT_ON_DONE=0:
  - `reset` pulsed at RUN edge 20: required all outputs return to reset values the next cycle, and the HOLD sequence restarts.
  - After pass: required `cpu_reset` = 0 in DONE.
